// File: rtl/mmio_sseg_display.sv
// Memory-mapped seven-segment display driver with register readback and switch input.
// Define SSEG_DP_EN to add the per-digit decimal-point register at BASE_ADDR+12.
module mmio_sseg_display #(
    parameter logic [31:0] BASE_ADDR    = 32'h80,
    parameter int          DIGIT_CYCLES = 4096,
    parameter int          CNT_W        = 16
) (
    input  logic        clksec,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic [7:0]  switches,
    output logic [31:0] readdata,
    output logic        hit,
    output logic [3:0]  top_an,
    output logic [7:0]  top_sseg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

    typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} scan_t;

    scan_t            state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic [1:0]       idx;
    logic [15:0]      disp;
    logic [3:0]       mask;
    logic [3:0]       dp;
    logic [7:0]       sw_p0, sw_p1;
    logic             sel_disp, sel_mask, sel_sw, sel_dp;
    logic [3:0]       an_next;
    logic [7:0]       sseg_next;
    logic             digit_on;
    logic             unused_bits;

    assign unused_bits = &{1'b0, writedata[31:16]};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Exact word-address decode; unaligned addresses never select a register.
    assign sel_disp = (dataadr == BASE_ADDR);
    assign sel_mask = (dataadr == BASE_ADDR + 32'd4);
    assign sel_sw   = (dataadr == BASE_ADDR + 32'd8);
`ifdef SSEG_DP_EN
    assign sel_dp   = (dataadr == BASE_ADDR + 32'd12);
`else
    assign sel_dp   = 1'b0;
    assign dp       = 4'h0;
`endif

    always_ff @(posedge clksec) begin
        if (reset) begin
            disp <= 16'h0;
            mask <= 4'hF;
`ifdef SSEG_DP_EN
            dp   <= 4'h0;
`endif
        end else if (memwrite) begin
            if (sel_disp) disp <= writedata[15:0];
            if (sel_mask) mask <= writedata[3:0];
`ifdef SSEG_DP_EN
            if (sel_dp)   dp   <= writedata[3:0];
`endif
        end
    end

    // Switch synchronizer, two stages
    always_ff @(posedge clksec) begin
        if (reset) begin
            sw_p0 <= 8'h0;
            sw_p1 <= 8'h0;
        end else begin
            sw_p0 <= switches;
            sw_p1 <= sw_p0;
        end
    end

    always_comb begin
        readdata = 32'h0;
        hit      = 1'b0;
        if (sel_disp) begin
            hit      = 1'b1;
            readdata = {16'h0, disp};
        end else if (sel_mask) begin
            hit      = 1'b1;
            readdata = {28'h0, mask};
        end else if (sel_sw) begin
            hit      = 1'b1;
            readdata = {24'h0, sw_p1};
        end else if (sel_dp) begin
            hit      = 1'b1;
            readdata = {28'h0, dp};
        end
    end

    // Scan FSM: state register, next-state logic, output logic
    assign wrap = (cnt == CNT_LAST);

    always_ff @(posedge clksec) begin
        if (reset) begin
            cnt   <= '0;
            state <= SCAN0;
        end else begin
            cnt   <= wrap ? '0 : cnt + 1'b1;
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SCAN0:   if (wrap) state_next = SCAN1;
            SCAN1:   if (wrap) state_next = SCAN2;
            SCAN2:   if (wrap) state_next = SCAN3;
            default: if (wrap) state_next = SCAN0;
        endcase
    end

    assign idx = state;

    always_comb begin
        digit_on  = mask[idx];
        an_next   = 4'hF;
        sseg_next = 8'hFF;
        if (digit_on) begin
            an_next   = ~(4'b0001 << idx);
            sseg_next = {~dp[idx], hex_to_seg(disp[{idx, 2'b00} +: 4])};
        end
    end

    // Output stage: one cycle behind the scan index and register contents
    always_ff @(posedge clksec) begin
        if (reset) begin
            top_an   <= 4'hF;
            top_sseg <= 8'hFF;
        end else begin
            top_an   <= an_next;
            top_sseg <= sseg_next;
        end
    end

endmodule

// File: tb/tb_mmio_sseg_display.sv
// Bench for mmio_sseg_display: table-driven bus vectors plus a display scoreboard.
// Honours SSEG_DP_EN for the decimal-point register expectations.
module tb_mmio_sseg_display;

    logic        clksec = 1'b0;
    logic        reset, memwrite;
    logic [31:0] dataadr, writedata, readdata;
    logic [7:0]  switches, top_sseg;
    logic        hit;
    logic [3:0]  top_an;

    always #5 clksec = ~clksec;

    mmio_sseg_display #(.BASE_ADDR(32'h80), .DIGIT_CYCLES(4), .CNT_W(16)) dut (
        .clksec(clksec), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .switches(switches), .readdata(readdata), .hit(hit),
        .top_an(top_an), .top_sseg(top_sseg)
    );

`ifdef SSEG_DP_EN
    localparam bit          HIT_DP = 1'b1;
    localparam logic [31:0] DP_RD  = 32'h1;
`else
    localparam bit          HIT_DP = 1'b0;
    localparam logic [31:0] DP_RD  = 32'h0;
`endif

    typedef struct {
        bit          rst;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  sw;
        bit          chk;
        bit          ehit;
        logic [31:0] erd;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [7:0] sseg;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0] m_disp;
    logic [3:0]  m_mask, m_dp;
    logic [1:0]  m_idx;
    int          m_cnt;

    function automatic vec_t mkv(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [7:0] s,
                                 bit c, bit h, logic [31:0] e);
        vec_t v;
        v.rst = r; v.we = w; v.addr = a; v.wdata = d; v.sw = s;
        v.chk = c; v.ehit = h; v.erd = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, predict the next registered
    // display output, then compare it after the rising edge.
    task automatic apply(input vec_t v);
        exp_t e;
        reset = v.rst; memwrite = v.we; dataadr = v.addr; writedata = v.wdata; switches = v.sw;
        #1;
        if (v.chk) begin
            check("hit", {31'h0, hit}, {31'h0, v.ehit});
            check("readdata", readdata, v.erd);
        end
        if (v.rst) begin
            e.an = 4'hF; e.sseg = 8'hFF;
            m_disp = 16'h0; m_mask = 4'hF; m_dp = 4'h0; m_cnt = 0; m_idx = 2'd0;
        end else begin
            e.an = 4'hF; e.sseg = 8'hFF;
            if (m_mask[m_idx]) begin
                e.an   = ~(4'b0001 << m_idx);
                e.sseg = {~m_dp[m_idx], seg_tab[m_disp[m_idx*4 +: 4]]};
            end
            if (v.we && v.addr == 32'h80) m_disp = v.wdata[15:0];
            if (v.we && v.addr == 32'h84) m_mask = v.wdata[3:0];
`ifdef SSEG_DP_EN
            if (v.we && v.addr == 32'h8C) m_dp = v.wdata[3:0];
`endif
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_idx = m_idx + 2'd1;
            end else begin
                m_cnt++;
            end
        end
        sb.push_back(e);
        @(posedge clksec);
        @(negedge clksec);
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check("top_an", {28'h0, top_an}, {28'h0, e.an});
            check("top_sseg", {24'h0, top_sseg}, {24'h0, e.sseg});
        end
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; dataadr = 32'h0; writedata = 32'h0; switches = 8'h0;

        for (int i = 0; i < 3; i++) tbl.push_back(mkv(1, 0, 32'h0, 32'h0, 8'h0, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 0, 32'h80, 32'h0, 8'h0, 1, 1, 32'h0));
        tbl.push_back(mkv(0, 0, 32'h84, 32'h0, 8'h0, 1, 1, 32'hF));
        tbl.push_back(mkv(0, 0, 32'h88, 32'h0, 8'h0, 1, 1, 32'h0));
        tbl.push_back(mkv(0, 0, 32'h8C, 32'h0, 8'h0, 1, HIT_DP, 32'h0));
        for (int i = 0; i < 4; i++) tbl.push_back(mkv(0, 0, 32'h0, 32'h0, 8'h0, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, 32'h80, 32'hDEAD1234, 8'h0, 1, 1, 32'h0));
        tbl.push_back(mkv(0, 0, 32'h80, 32'h0, 8'h0, 1, 1, 32'h1234));
        for (int i = 0; i < 16; i++) tbl.push_back(mkv(0, 0, 32'h0, 32'h0, 8'h0, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, 32'h84, 32'h5, 8'h0, 1, 1, 32'hF));
        tbl.push_back(mkv(0, 0, 32'h84, 32'h0, 8'h0, 1, 1, 32'h5));
        for (int i = 0; i < 16; i++) tbl.push_back(mkv(0, 0, 32'h0, 32'h0, 8'h0, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 0, 32'h0, 32'h0, 8'hA5, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 0, 32'h0, 32'h0, 8'hA5, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 0, 32'h88, 32'h0, 8'hA5, 1, 1, 32'hA5));
        tbl.push_back(mkv(0, 1, 32'h88, 32'hFF, 8'hA5, 1, 1, 32'hA5));
        tbl.push_back(mkv(0, 0, 32'h80, 32'h0, 8'hA5, 1, 1, 32'h1234));
        tbl.push_back(mkv(0, 0, 32'h84, 32'h0, 8'hA5, 1, 1, 32'h5));
        tbl.push_back(mkv(0, 0, 32'h90, 32'h0, 8'hA5, 1, 0, 32'h0));
        tbl.push_back(mkv(0, 1, 32'h81, 32'hFFFF, 8'hA5, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, 32'h90, 32'h0, 8'hA5, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 1, 32'h7C, 32'h0, 8'hA5, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 0, 32'h80, 32'h0, 8'hA5, 1, 1, 32'h1234));
        tbl.push_back(mkv(0, 0, 32'h84, 32'h0, 8'hA5, 1, 1, 32'h5));
        tbl.push_back(mkv(0, 1, 32'h8C, 32'h1, 8'hA5, 1, HIT_DP, 32'h0));
        tbl.push_back(mkv(0, 0, 32'h8C, 32'h0, 8'hA5, 1, HIT_DP, DP_RD));
        tbl.push_back(mkv(0, 1, 32'h84, 32'hF, 8'hA5, 0, 0, 32'h0));
        for (int i = 0; i < 16; i++) tbl.push_back(mkv(0, 0, 32'h0, 32'h0, 8'hA5, 0, 0, 32'h0));

        @(negedge clksec);
        foreach (tbl[i]) apply(tbl[i]);

        // Reset while scanning digit 2, with a competing store to DISP
        for (int k = 0; k < 20 && !(m_idx == 2'd2 && m_cnt == 1); k++)
            apply(mkv(0, 0, 32'h0, 32'h0, 8'hA5, 0, 0, 32'h0));
        apply(mkv(1, 1, 32'h80, 32'h7, 8'hA5, 0, 0, 32'h0));
        apply(mkv(0, 0, 32'h80, 32'h0, 8'hA5, 1, 1, 32'h0));
        apply(mkv(0, 0, 32'h84, 32'h0, 8'hA5, 1, 1, 32'hF));
        apply(mkv(0, 0, 32'h8C, 32'h0, 8'hA5, 1, HIT_DP, 32'h0));

        // Store landing on the counter-wrap edge
        for (int k = 0; k < 8 && m_cnt != 3; k++)
            apply(mkv(0, 0, 32'h0, 32'h0, 8'hA5, 0, 0, 32'h0));
        apply(mkv(0, 1, 32'h80, 32'hABCD, 8'hA5, 0, 0, 32'h0));
        for (int i = 0; i < 12; i++) apply(mkv(0, 0, 32'h0, 32'h0, 8'hA5, 0, 0, 32'h0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_sseg_display.md
Name: mmio_sseg_display

Overview:
- Memory-mapped store responder on the MIPS data bus (`memwrite`/`dataadr`/`writedata`), on the bus side opposite the store-watching bench.
- Decodes CPU stores into a display register and a digit-enable register.
- Drives a 4-digit multiplexed seven-segment display (`top_an`/`top_sseg`).
- Returns register and switch values on loads, so programs can read back what they wrote and poll `switches`.

Parameters:
- `BASE_ADDR`, `32'h80`: word address of register 0; decode window is `BASE_ADDR`..`BASE_ADDR+12`.
- `DIGIT_CYCLES`, `4096`: clock cycles each digit stays lit before the scan advances (legal range 2..65535).
- `CNT_W`, `16`: width of the refresh counter; must satisfy 2^`CNT_W` >= `DIGIT_CYCLES`.

Ports:
- `clksec`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  CPU store strobe for the current cycle.
- `dataadr`  in  32  CPU byte address.
- `writedata`  in  32  CPU store data.
- `switches`  in  8  board switches, sampled through a 2-flop synchronizer.
- `readdata`  out  32  load data for a decoded address; 0 otherwise.
- `hit`  out  1  `dataadr` falls in the decode window; top level uses it to mux `readdata` against data memory.
- `top_an`  out  4  digit anodes, active-low.
- `top_sseg`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Register map (word offsets):
  - +0 `DISP`: RW, 16 bits, four hex nibbles; digit 0 = bits[3:0].
  - +4 `MASK`: RW, 4 bits, digit enables.
  - +8 `SW`: RO, synchronized switches, zero-extended.
  - +12 `DP`: see Optional Feature.
- Store decode: a write takes effect on the rising edge where `memwrite`=1 and `dataadr` matches exactly. Only the low bits defined per register are stored.
- Ignored stores: writes to `SW`, to unaligned addresses, and to addresses outside the window have no effect.
- `hit` and `readdata` are combinational from `dataadr` and current register state, with zero cycles of latency, to match the single-cycle CPU. Unimplemented bits read as 0.
- A load in the same cycle as a store to the same register returns the old value. The new value is visible the following cycle.
- Refresh counter `cnt`:
  - Increments every cycle.
  - On `cnt`==`DIGIT_CYCLES`-1 it wraps to 0 and digit index `idx` advances 0→1→2→3→0.
- Scan FSM: states `SCAN0`..`SCAN3`, equal to `idx`; transition only on counter wrap.
- Output registers, updated every cycle from the current `idx`:
  - `top_an` <= ~(1<<`idx`) when `MASK`[`idx`]=1; otherwise 4'hF.
  - `top_sseg` <= hex-to-seg(`DISP` nibble `idx`) when enabled; otherwise 8'hFF.
  - Segment latency is 1 cycle from a register change to the output.
- Hex encoding, active-low {g..a}:

  | Value | Code | Value | Code | Value | Code | Value | Code |
  |---|---|---|---|---|---|---|---|
  | 0 | 7'h40 | 4 | 7'h19 | 8 | 7'h00 | C | 7'h46 |
  | 1 | 7'h79 | 5 | 7'h12 | 9 | 7'h10 | D | 7'h21 |
  | 2 | 7'h24 | 6 | 7'h02 | A | 7'h08 | E | 7'h06 |
  | 3 | 7'h30 | 7 | 7'h78 | B | 7'h03 | F | 7'h0E |

- Reset values:
  - `DISP`=0, `MASK`=4'hF, `cnt`=0, `idx`=0.
  - Synchronizer flops 0.
  - `top_an`=4'hF, `top_sseg`=8'hFF.
- First cycle after reset release: `top_an`=4'hE with digit 0's pattern registered.
- Reset mid-scan: next edge returns to `SCAN0`, `cnt`=0, outputs blanked. Registers are cleared even if `memwrite` is asserted in the reset cycle; reset wins.
- A store during a counter-wrap edge: new data appears on the new digit one cycle later. No glitch value is ever registered.

Optional Feature:
- Macro `SSEG_DP_EN`.
- Defined:
  - `DP` register at +12, RW, 4 bits, reset 0.
  - `top_sseg`[7] = ~`DP`[`idx`] for enabled digits; 1 when masked.
  - `hit` covers +12.
- Undefined:
  - +12 is outside the window: `hit`=0, `readdata`=0, stores ignored.
  - `top_sseg`[7] is always 1.

Test Plan (`DIGIT_CYCLES`=4, `BASE_ADDR`=`32'h80`):
1. Assert `reset` 3 cycles, release → cycle 1: `top_an`=4'hE, `top_sseg`=8'hC0; after 4 cycles `top_an`=4'hD.
2. Store 32'hDEAD1234 to 0x80, then load 0x80 → `readdata`=32'h00001234. Digits 0..3 show 8'h99, 8'hB0, 8'hA4, 8'hF9 in scan order.
3. Store 32'h5 to 0x84 → digits 1 and 3 show `top_an`=4'hF and `top_sseg`=8'hFF in their slots. Load 0x84 returns 32'h5.
4. Set `switches`=8'hA5; after 2 cycles load 0x88 → 32'h000000A5, `hit`=1. Store 32'hFF to 0x88 leaves `DISP`/`MASK` unchanged. Load 0x90 → `hit`=0, `readdata`=0.
5. Assert `reset` with `memwrite`=1, `dataadr`=0x80, `writedata`=7 while mid-scan at digit 2 → next cycle `DISP`=0, `idx`=0, `top_an`=4'hF.
6. With `SSEG_DP_EN`: store 32'h1 to 0x8C → digit 0 `top_sseg`[7]=0, other digits 1. Without the macro: load 0x8C → `hit`=0, and dp is always 1.
